// File: rtl/axis_heap_loader.sv
// rtl/axis_heap_loader.sv - AXI-Stream packet loader into heap memory write port
module axis_heap_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              axis_clk,
    input  logic              axis_aresetn,
    input  logic [31:0]       axis_tdata,
    input  logic              axis_tkeep,
    input  logic              axis_tlast,
    input  logic              axis_tvalid,
    output logic              axis_tready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic [3:0]        mem_wr_en,
    input  logic              mem_ready,
    input  logic              clear,
    output logic              busy,
    output logic              err_len,
    output logic              err_range,
    output logic [15:0]       pkt_count
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    typedef enum logic [1:0] {S_HDR, S_DATA, S_DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_ptr;
    logic [15:0]       remaining;

    logic        pending;
    logic        fire;
    logic        data_beat;
    logic [15:0] hdr_len;
    logic [15:0] hdr_base;
    logic        hdr_over;
    logic        set_len;
    logic        set_range;
    logic        inc;

    assign pending   = |mem_wr_en;
    assign fire      = axis_tvalid && axis_tready;
    assign data_beat = fire && axis_tkeep;
    assign hdr_len   = axis_tdata[31:16];
    assign hdr_base  = axis_tdata[15:0];
    // 17-bit sum so a base near 64K cannot wrap back into range
    assign hdr_over  = ({1'b0, hdr_base} + {1'b0, hdr_len}) > DEPTH;
    assign busy      = (state != S_HDR) || pending;

    always_comb begin
        axis_tready = 1'b1;
        if (state == S_DATA) begin
            axis_tready = !pending || mem_ready;
        end
    end

    always_comb begin
        set_len   = 1'b0;
        set_range = 1'b0;
        inc       = 1'b0;
        case (state)
            S_HDR: begin
                if (data_beat) begin
                    if (hdr_over) begin
                        set_range = 1'b1;
                    end else if (hdr_len == 16'd0) begin
                        if (axis_tlast) inc = 1'b1;
                        else            set_len = 1'b1;
                    end else if (axis_tlast) begin
                        set_len = 1'b1;
                    end
                end
            end
            S_DATA: begin
                // a null beat carrying tlast still closes the packet
                if (fire && axis_tlast) begin
                    if (remaining == 16'd1) inc = 1'b1;
                    else                    set_len = 1'b1;
                end else if (data_beat && remaining == 16'd1) begin
                    set_len = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state       <= S_HDR;
            addr_ptr    <= '0;
            remaining   <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr_en   <= 4'h0;
            err_len     <= 1'b0;
            err_range   <= 1'b0;
            pkt_count   <= 16'd0;
        end else begin
            err_len   <= (err_len && !clear) || set_len;
            err_range <= (err_range && !clear) || set_range;
            pkt_count <= (clear ? 16'd0 : pkt_count) + {15'd0, inc};
            if (mem_ready) begin
                mem_wr_en <= 4'h0;
            end
            case (state)
                S_HDR: begin
                    if (data_beat) begin
                        addr_ptr  <= hdr_base[ADDR_W-1:0];
                        remaining <= hdr_len;
                        if (!axis_tlast) begin
                            state <= (hdr_over || hdr_len == 16'd0) ? S_DRAIN : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (data_beat) begin
                        mem_addr    <= addr_ptr;
                        mem_wr_data <= axis_tdata;
                        mem_wr_en   <= 4'hF;
                        addr_ptr    <= addr_ptr + ADDR_W'(1);
                        remaining   <= remaining - 16'd1;
                    end
                    if (fire && axis_tlast) begin
                        state <= S_HDR;
                    end else if (data_beat && remaining == 16'd1) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fire && axis_tlast) begin
                        state <= S_HDR;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_heap_loader.sv
// tb/tb_axis_heap_loader.sv - randomized packet bench with packet-level reference model
module tb_axis_heap_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    logic              axis_clk = 1'b0;
    logic              axis_aresetn = 1'b0;
    logic [31:0]       axis_tdata = '0;
    logic              axis_tkeep = 1'b0;
    logic              axis_tlast = 1'b0;
    logic              axis_tvalid = 1'b0;
    logic              axis_tready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic [3:0]        mem_wr_en;
    logic              mem_ready = 1'b1;
    logic              clear = 1'b0;
    logic              busy;
    logic              err_len;
    logic              err_range;
    logic [15:0]       pkt_count;

    axis_heap_loader #(.ADDR_W(ADDR_W)) dut (
        .axis_clk    (axis_clk),
        .axis_aresetn(axis_aresetn),
        .axis_tdata  (axis_tdata),
        .axis_tkeep  (axis_tkeep),
        .axis_tlast  (axis_tlast),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .mem_ready   (mem_ready),
        .clear       (clear),
        .busy        (busy),
        .err_len     (err_len),
        .err_range   (err_range),
        .pkt_count   (pkt_count)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] pay_q[$];
    logic        exp_len = 1'b0;
    logic        exp_rng = 1'b0;
    logic [15:0] exp_cnt = 16'd0;
    int          frames_done = 0;
    bit          rand_ready = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ready();
        mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Whole-packet view: which words land where and how the status changes
    task automatic model_frame(input logic [31:0] hdr, input logic hdr_last, input bit clr);
        int len;
        int base;
        int k;
        len  = int'(hdr[31:16]);
        base = int'(hdr[15:0]);
        if (clr) begin
            exp_len = 1'b0;
            exp_rng = 1'b0;
            exp_cnt = 16'd0;
        end
        if (base + len > DEPTH) begin
            exp_rng = 1'b1;
        end else if (hdr_last) begin
            if (len == 0) exp_cnt++;
            else          exp_len = 1'b1;
        end else if (len == 0) begin
            exp_len = 1'b1;
        end else begin
            k = (pay_q.size() < len) ? pay_q.size() : len;
            for (int i = 0; i < k; i++) begin
                exp_q.push_back(wr_t'{addr: 32'(base + i), data: pay_q[i]});
            end
            if (pay_q.size() == len) exp_cnt++;
            else                     exp_len = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic k, input logic l, input logic c);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(negedge axis_clk);
            axis_tvalid = 1'b0;
            axis_tdata  = $urandom;
            clear       = 1'b0;
            set_ready();
        end
        while (!done) begin
            @(negedge axis_clk);
            axis_tvalid = 1'b1;
            axis_tdata  = d;
            axis_tkeep  = k;
            axis_tlast  = l;
            clear       = c;
            set_ready();
            #1;
            if (axis_tready) begin
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 200) begin
                    $display("FAIL beat_timeout: got tready=0 for %0d cycles expected acceptance", guard);
                    $fatal(1);
                end
            end
        end
        @(posedge axis_clk);
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic hdr_last, input int n,
                              input bit nulls, input bit clr);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back($urandom);
        model_frame(hdr, hdr_last, clr);
        send_beat(hdr, 1'b1, hdr_last, 1'b0);
        if (!hdr_last) begin
            for (int i = 0; i < n; i++) begin
                if (nulls && $urandom_range(0, 2) == 0) send_beat($urandom, 1'b0, 1'b0, 1'b0);
                send_beat(pay_q[i], 1'b1, 1'(i == n - 1), 1'(clr && (i == n - 1)));
            end
        end
        @(negedge axis_clk);
        axis_tvalid = 1'b0;
        clear       = 1'b0;
        set_ready();
        frames_done++;
        #3;
    endtask

    // Per-cycle compare against the model's write queue and status
    initial begin
        logic [ADDR_W-1:0] pa;
        logic [31:0]       pd;
        logic [3:0]        pe;
        bit                pstall;
        int                seen;
        wr_t               w;
        pstall = 1'b0;
        seen   = 0;
        forever begin
            @(negedge axis_clk);
            #2;
            if (!axis_aresetn) begin
                pstall = 1'b0;
                continue;
            end
            if (pstall) begin
                check("stall_addr", 32'(mem_addr), 32'(pa));
                check("stall_data", mem_wr_data, pd);
                check("stall_en", 32'(mem_wr_en), 32'(pe));
            end
            if (!(mem_wr_en != 4'h0 && !mem_ready)) begin
                check("tready_free", 32'(axis_tready), 32'd1);
            end
            if (mem_wr_en != 4'h0 && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    check("mem_addr", 32'(mem_addr), w.addr);
                    check("mem_wr_data", mem_wr_data, w.data);
                    check("mem_wr_en", 32'(mem_wr_en), 32'hF);
                end
            end
            pstall = (mem_wr_en != 4'h0) && !mem_ready;
            pa = mem_addr;
            pd = mem_wr_data;
            pe = mem_wr_en;
            if (frames_done != seen) begin
                seen = frames_done;
                check("err_len", 32'(err_len), 32'(exp_len));
                check("err_range", 32'(err_range), 32'(exp_rng));
                check("pkt_count", 32'(pkt_count), 32'(exp_cnt));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        int base;
        int n;
        logic [31:0] hdr;

        repeat (3) @(negedge axis_clk);
        check("rst_tready", 32'(axis_tready), 32'd1);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", mem_wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {30'd0, err_len, err_range}, 32'd0);
        check("rst_count", 32'(pkt_count), 32'd0);
        axis_aresetn = 1'b1;

        rand_ready = 1'b0;
        send_frame(32'h0004_0010, 1'b0, 4, 1'b0, 1'b0);
        check("good_count", 32'(pkt_count), 32'd1);
        check("good_model_count", 32'(exp_cnt), 32'd1);
        check("good_err", {30'd0, err_len, err_range}, 32'd0);

        rand_ready = 1'b1;
        send_frame(32'h0004_0010, 1'b0, 4, 1'b0, 1'b0);
        check("bp_count", 32'(pkt_count), 32'd2);

        send_frame(32'h0002_0FFF, 1'b0, 2, 1'b0, 1'b0);
        check("range_err", 32'(err_range), 32'd1);
        send_frame(32'h0001_0FFF, 1'b0, 1, 1'b0, 1'b0);
        check("range_edge_count", 32'(pkt_count), 32'd3);

        send_frame(32'h0003_0020, 1'b0, 2, 1'b0, 1'b0);
        check("early_err_len", 32'(err_len), 32'd1);
        check("early_count", 32'(pkt_count), 32'd3);
        send_frame(32'h0001_0030, 1'b0, 3, 1'b0, 1'b0);

        send_frame(32'h0002_0040, 1'b0, 2, 1'b0, 1'b1);
        check("clr_flags", {30'd0, err_len, err_range}, 32'd0);
        check("clr_count", 32'(pkt_count), 32'd1);

        send_frame(32'h0003_0050, 1'b0, 3, 1'b1, 1'b0);
        send_frame(32'h0000_0000, 1'b1, 0, 1'b0, 1'b0);
        check("null_len0_count", 32'(pkt_count), 32'd3);

        for (int f = 0; f < 300; f++) begin
            rand_ready = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 6);
            case ($urandom_range(0, 7))
                0:       base = DEPTH - len - 1 + $urandom_range(0, 2);
                1:       base = $urandom_range(DEPTH, 65535);
                default: base = $urandom_range(0, DEPTH - 8);
            endcase
            hdr = {len[15:0], base[15:0]};
            if (len > 0 && base + len <= DEPTH) begin
                n = len - 1 + $urandom_range(0, 2);
                if (n < 1) n = 1;
            end else begin
                n = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 9) == 0) send_beat($urandom, 1'b0, 1'b1, 1'b0);
            send_frame(hdr, 1'($urandom_range(0, 5) == 0), n, 1'($urandom_range(0, 1)), 1'b0);
        end

        rand_ready = 1'b0;
        repeat (4) begin
            @(negedge axis_clk);
            mem_ready = 1'b1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        send_beat(32'h0005_0100, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(wr_t'{addr: 32'h100, data: 32'hA5A5_0001});
        send_beat(32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
        send_beat(32'hA5A5_0002, 1'b1, 1'b0, 1'b0);
        @(negedge axis_clk);
        axis_aresetn = 1'b0;
        axis_tvalid  = 1'b0;
        #1;
        check("mid_rst_tready", 32'(axis_tready), 32'd1);
        check("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_data", mem_wr_data, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_flags", {30'd0, err_len, err_range}, 32'd0);
        check("mid_rst_count", 32'(pkt_count), 32'd0);
        exp_q.delete();
        exp_len = 1'b0;
        exp_rng = 1'b0;
        exp_cnt = 16'd0;
        @(negedge axis_clk);
        axis_aresetn = 1'b1;
        send_frame(32'h0002_0200, 1'b0, 2, 1'b0, 1'b0);
        check("post_rst_count", 32'(pkt_count), 32'd1);
        repeat (3) @(negedge axis_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
